// File: rtl/motion_pkg.sv
// Shared definitions for the rectangle motion block and the render stage.
package motion_pkg;

   // Default geometry, shared with the render stage so both agree on the travel range
   localparam int H_RES_DEF      = 640;
   localparam int RECT_WIDTH_DEF = 200;

   typedef enum logic [2:0] {
      RIGHT  = 3'd0,
      LEFT   = 3'd1,
      HOLD_R = 3'd2,
      HOLD_L = 3'd3,
      PAUSE  = 3'd4
   } motion_state_t;

   // A speed of zero would stall the animation, so it is promoted to one pixel
   function automatic logic [10:0] step_of(input logic [2:0] speed);
      return (speed == 3'd0) ? 11'd1 : {8'd0, speed};
   endfunction

endpackage

// File: rtl/frame_strobe.sv
// Once-per-frame update strobe, decoded from the timing generator counters.
module frame_strobe
   import motion_pkg::*;
#(
   parameter int UPDATE_LINE = 480
) (
   input  logic       clk_pix,
   input  logic       rst_pix,
   input  logic [9:0] sx,
   input  logic [9:0] sy,
   output logic       tick
);

   localparam logic [9:0] LINE = 10'(UPDATE_LINE);

   logic r_tick;

   // Register the first-pixel-of-blanking-line decode so tick is a clean one-cycle pulse
   always_ff @(posedge clk_pix or posedge rst_pix) begin
      if (rst_pix) begin
         r_tick <= 1'b0;
      end else begin
         r_tick <= (sx == 10'd0) && (sy == LINE);
      end
   end

   assign tick = r_tick;

endmodule

// File: rtl/rect_motion.sv
// Bouncing rectangle position: moves once per frame, holds at each edge, pausable.
module rect_motion
   import motion_pkg::*;
#(
   parameter int H_RES       = H_RES_DEF,
   parameter int RECT_WIDTH  = RECT_WIDTH_DEF,
   parameter int UPDATE_LINE = 480,
   parameter int HOLD_FRAMES = 30
) (
   input  logic       clk_pix,
   input  logic       rst_pix,
   input  logic [9:0] sx,
   input  logic [9:0] sy,
   input  logic       run,
   input  logic [2:0] speed,
   output logic [9:0] sympos,
   output logic       dir,
   output logic       bounce
);

   localparam logic [10:0] MAX       = 11'(H_RES - RECT_WIDTH);
   localparam logic [7:0]  HOLD_INIT = (HOLD_FRAMES > 0) ? 8'(HOLD_FRAMES - 1) : 8'd0;
   localparam bit          HAS_HOLD  = (HOLD_FRAMES > 0);

   if (RECT_WIDTH >= H_RES || HOLD_FRAMES > 255) begin : g_param_err
      $error("rect_motion: RECT_WIDTH must be below H_RES and HOLD_FRAMES must not exceed 255");
   end

   motion_state_t r_state, r_resume;
   logic [9:0]    r_sympos;
   logic          r_dir, r_bounce;
   logic [7:0]    r_hold_cnt;

   logic          w_tick;
   motion_state_t w_eff;
   motion_state_t w_state_nx, w_resume_nx;
   logic [9:0]    w_sympos_nx;
   logic          w_dir_nx, w_bounce_nx;
   logic [7:0]    w_hold_nx;
   logic [10:0]   w_step, w_sum;
   logic          w_go_right, w_go_left;

   frame_strobe #(
      .UPDATE_LINE(UPDATE_LINE)
   ) u_strobe (
      .clk_pix (clk_pix),
      .rst_pix (rst_pix),
      .sx      (sx),
      .sy      (sy),
      .tick    (w_tick)
   );

   // Leaving PAUSE performs the saved state's action on the same tick
   assign w_eff  = (r_state == PAUSE) ? r_resume : r_state;
   assign w_step = step_of(speed);
   assign w_sum  = {1'b0, r_sympos} + w_step;

   // Next-state logic; everything holds except on a tick, and bounce defaults low
   always_comb begin
      w_state_nx  = r_state;
      w_resume_nx = r_resume;
      w_sympos_nx = r_sympos;
      w_dir_nx    = r_dir;
      w_bounce_nx = 1'b0;
      w_hold_nx   = r_hold_cnt;
      w_go_right  = 1'b0;
      w_go_left   = 1'b0;
      if (w_tick) begin
         if (!run) begin
            if (r_state != PAUSE) begin
               w_resume_nx = r_state;
               w_state_nx  = PAUSE;
            end
         end else begin
            case (w_eff)
               RIGHT:  w_go_right = 1'b1;
               LEFT:   w_go_left  = 1'b1;
               HOLD_R: begin
                  if (r_hold_cnt == 8'd0) begin
                     w_go_left = 1'b1;
                  end else begin
                     w_hold_nx  = r_hold_cnt - 8'd1;
                     w_state_nx = HOLD_R;
                  end
               end
               HOLD_L: begin
                  if (r_hold_cnt == 8'd0) begin
                     w_go_right = 1'b1;
                  end else begin
                     w_hold_nx  = r_hold_cnt - 8'd1;
                     w_state_nx = HOLD_L;
                  end
               end
               default: w_state_nx = RIGHT;
            endcase
         end
         if (w_go_right) begin
            if (w_sum >= MAX) begin
               w_sympos_nx = MAX[9:0];
               w_bounce_nx = 1'b1;
               w_dir_nx    = 1'b1;
               w_hold_nx   = HOLD_INIT;
               w_state_nx  = HAS_HOLD ? HOLD_R : LEFT;
            end else begin
               w_sympos_nx = w_sum[9:0];
               w_state_nx  = RIGHT;
            end
         end
         if (w_go_left) begin
            if ({1'b0, r_sympos} <= w_step) begin
               w_sympos_nx = 10'd0;
               w_bounce_nx = 1'b1;
               w_dir_nx    = 1'b0;
               w_hold_nx   = HOLD_INIT;
               w_state_nx  = HAS_HOLD ? HOLD_L : RIGHT;
            end else begin
               w_sympos_nx = r_sympos - w_step[9:0];
               w_state_nx  = LEFT;
            end
         end
      end
   end

   // State register; reset forces the rest position immediately, without a clock
   always_ff @(posedge clk_pix or posedge rst_pix) begin
      if (rst_pix) begin
         r_state    <= RIGHT;
         r_resume   <= RIGHT;
         r_sympos   <= 10'd0;
         r_dir      <= 1'b0;
         r_bounce   <= 1'b0;
         r_hold_cnt <= 8'd0;
      end else begin
         r_state    <= w_state_nx;
         r_resume   <= w_resume_nx;
         r_sympos   <= w_sympos_nx;
         r_dir      <= w_dir_nx;
         r_bounce   <= w_bounce_nx;
         r_hold_cnt <= w_hold_nx;
      end
   end

   assign sympos = r_sympos;
   assign dir    = r_dir;
   assign bounce = r_bounce;

endmodule

// File: tb/tb_rect_motion.sv
// Scoreboard bench for rect_motion with a compressed frame timing stimulus.
module tb_rect_motion;

   localparam int MAX  = 440;
   localparam int HOLD = 30;

   logic       clk_pix = 1'b0;
   logic       rst_pix;
   logic [9:0] sx, sy;
   logic       run;
   logic [2:0] speed;
   logic [9:0] sympos;
   logic       dir, bounce;

   bit clk_en = 1'b1;
   bit done   = 1'b0;
   int cyc    = 0;
   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int due;
      int kind;
      int pos;
      bit dir;
      bit bnc;
   } exp_t;
   exp_t q[$];

   // reference model: position, direction, remaining stationary ticks
   int m_pos, m_holds;
   bit m_dir, m_bnc;

   rect_motion dut (
      .clk_pix (clk_pix),
      .rst_pix (rst_pix),
      .sx      (sx),
      .sy      (sy),
      .run     (run),
      .speed   (speed),
      .sympos  (sympos),
      .dir     (dir),
      .bounce  (bounce)
   );

   always #5 if (clk_en) clk_pix = ~clk_pix;

   always @(posedge clk_pix) cyc <= cyc + 1;

   function automatic string kname(input int k);
      case (k)
         0:  return "model";
         1:  return "ten_frames_pos20";
         2:  return "edge_440_bounce";
         3:  return "hold_440_29th";
         4:  return "leave_436";
         5:  return "left_bounce_0";
         6:  return "speed0_hold_exit";
         7:  return "speed0_second";
         8:  return "pause_frozen";
         9:  return "pause_resume";
         10: return "first_tick_after_rst";
         default: return "unknown";
      endcase
   endfunction

   task automatic model_tick(input logic r, input logic [2:0] s);
      int st;
      m_bnc = 1'b0;
      if (!r) return;
      st = (s == 3'd0) ? 1 : int'(s);
      if (m_holds > 0) begin
         m_holds--;
      end else if (!m_dir) begin
         if (m_pos + st >= MAX) begin
            m_pos = MAX; m_dir = 1'b1; m_bnc = 1'b1; m_holds = HOLD - 1;
         end else begin
            m_pos += st;
         end
      end else begin
         if (m_pos <= st) begin
            m_pos = 0; m_dir = 1'b0; m_bnc = 1'b1; m_holds = HOLD - 1;
         end else begin
            m_pos -= st;
         end
      end
   endtask

   task automatic filler(input bit keep);
      logic [9:0] x, y;
      case ($urandom_range(0, 5))
         0: begin x = 10'd0; y = 10'd479; end
         1: begin x = 10'd1; y = 10'd480; end
         2: begin x = 10'd0; y = 10'd481; end
         default: begin
            x = 10'($urandom_range(0, 799));
            y = 10'($urandom_range(0, 524));
            if (x == 10'd0 && y == 10'd480) x = 10'd5;
         end
      endcase
      @(posedge clk_pix); #1;
      sx = x; sy = y;
      if (!keep) begin
         run   = 1'($urandom_range(0, 1));
         speed = 3'($urandom_range(0, 7));
      end
   endtask

   task automatic frame(input logic r, input logic [2:0] s, input int k,
                        input int p, input bit d, input bit b);
      exp_t e;
      repeat ($urandom_range(1, 3)) filler(1'b0);
      @(posedge clk_pix); #1;
      sx = 10'd0; sy = 10'd480; run = r; speed = s;
      model_tick(r, s);
      e.due = cyc + 2; e.kind = 0; e.pos = m_pos; e.dir = m_dir; e.bnc = m_bnc;
      q.push_back(e);
      if (k != 0) begin
         e.kind = k; e.pos = p; e.dir = d; e.bnc = b;
         q.push_back(e);
      end
      filler(1'b1);
   endtask

   task automatic do_reset();
      repeat (3) filler(1'b1);
      @(negedge clk_pix); #1;
      clk_en = 1'b0;
      #2 rst_pix = 1'b1;
      #4 rst_pix = 1'b0;
      m_pos = 0; m_dir = 1'b0; m_holds = 0; m_bnc = 1'b0;
      #2 clk_en = 1'b1;
   endtask

   // stimulus
   initial begin
      int p, s;
      rst_pix = 1'b1; sx = 10'd5; sy = 10'd0; run = 1'b0; speed = 3'd0;
      m_pos = 0; m_dir = 1'b0; m_holds = 0; m_bnc = 1'b0;
      repeat (4) @(posedge clk_pix);
      #1 rst_pix = 1'b0;

      for (int i = 0; i < 10; i++) frame(1'b1, 3'd2, (i == 9) ? 1 : 0, 20, 1'b0, 1'b0);
      for (int i = 0; i < 209; i++) frame(1'b1, 3'd2, 0, 0, 1'b0, 1'b0);
      frame(1'b1, 3'd4, 2, 440, 1'b1, 1'b1);
      for (int i = 0; i < 29; i++) frame(1'b1, 3'd4, (i == 28) ? 3 : 0, 440, 1'b1, 1'b0);
      frame(1'b1, 3'd4, 4, 436, 1'b1, 1'b0);

      while (m_pos > 1) frame(1'b1, 3'((m_pos - 1 > 7) ? 7 : m_pos - 1), 0, 0, 1'b0, 1'b0);
      frame(1'b1, 3'd3, 5, 0, 1'b0, 1'b1);
      for (int i = 0; i < 29; i++) frame(1'b1, 3'd0, 0, 0, 1'b0, 1'b0);
      frame(1'b1, 3'd0, 6, 1, 1'b0, 1'b0);
      frame(1'b1, 3'd0, 7, 2, 1'b0, 1'b0);

      for (int i = 0; i < 3; i++) frame(1'b1, 3'd5, 0, 0, 1'b0, 1'b0);
      p = m_pos;
      for (int i = 0; i < 5; i++) frame(1'b0, 3'($urandom_range(0, 7)), 8, p, 1'b0, 1'b0);
      frame(1'b1, 3'd5, 9, p + 5, 1'b0, 1'b0);

      for (int i = 0; i < 150; i++)
         frame(1'($urandom_range(0, 4) != 0), 3'($urandom_range(0, 7)), 0, 0, 1'b0, 1'b0);

      for (int i = 0; i < 400 && !(m_dir == 1'b0 && m_holds >= 5 && m_holds <= 25); i++)
         frame(1'b1, 3'd7, 0, 0, 1'b0, 1'b0);
      do_reset();

      s = $urandom_range(0, 7);
      frame(1'b1, 3'(s), 10, (s == 0) ? 1 : s, 1'b0, 1'b0);

      for (int i = 0; i < 400 && !(m_dir == 1'b1 && m_holds >= 5 && m_holds <= 25); i++)
         frame(1'b1, 3'd7, 0, 0, 1'b0, 1'b0);
      do_reset();

      for (int i = 0; i < 20; i++)
         frame(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 0, 0, 1'b0, 1'b0);
      repeat (3) filler(1'b1);
      done = 1'b1;
   end

   // monitor: pops due expectations, otherwise requires outputs to stay put
   initial begin
      exp_t e;
      bit hit;
      int last_pos;
      bit last_dir;
      last_pos = 0; last_dir = 1'b0;
      forever begin
         @(negedge clk_pix or posedge rst_pix);
         if (rst_pix) begin
            #1;
            n_tests++;
            if (sympos !== 10'd0 || dir !== 1'b0 || bounce !== 1'b0) begin
               n_fail++;
               $display("FAIL reset: got sympos=%0d dir=%0b bounce=%0b, expected 0/0/0", sympos, dir, bounce);
            end
            last_pos = 0; last_dir = 1'b0;
         end else begin
            hit = 1'b0;
            while (q.size() > 0 && q[0].due <= cyc) begin
               e = q.pop_front();
               n_tests++;
               if (e.due != cyc || sympos !== 10'(e.pos) || dir !== e.dir || bounce !== e.bnc) begin
                  n_fail++;
                  $display("FAIL %s @cyc %0d (due %0d): got sympos=%0d dir=%0b bounce=%0b, expected %0d/%0b/%0b",
                           kname(e.kind), cyc, e.due, sympos, dir, bounce, e.pos, e.dir, e.bnc);
               end
               if (e.kind == 0) begin
                  last_pos = e.pos; last_dir = e.dir; hit = 1'b1;
               end
            end
            if (!hit) begin
               n_tests++;
               if (sympos !== 10'(last_pos) || dir !== last_dir || bounce !== 1'b0) begin
                  n_fail++;
                  $display("FAIL idle @cyc %0d sy=%0d: got sympos=%0d dir=%0b bounce=%0b, expected %0d/%0b/0",
                           cyc, sy, sympos, dir, bounce, last_pos, last_dir);
               end
            end
            if (cyc > 90000) begin
               n_fail++;
               $display("FAIL timeout: got cycle %0d, expected completion before 90000", cyc);
               $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
               $finish;
            end
            if (done) begin
               n_tests++;
               if (q.size() != 0) begin
                  n_fail++;
                  $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
               end
               $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
               $finish;
            end
         end
      end
   end

endmodule
